// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// mstatus bit positions and the ecall cause code.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;

  localparam int unsigned CAUSE_ECALL_M = 11;

  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_file_counter.sv
// Free-running counter with per-half software write; a write replaces the
// increment for that cycle and leaves the other half untouched.
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_val;

  generate
    if (CNT_W > XLEN) begin : g_wide
      assign wr_val = wr_hi_i ? {wdata_i[CNT_W-XLEN-1:0], cnt_q[XLEN-1:0]}
                              : {cnt_q[CNT_W-1:XLEN], wdata_i};
    end else begin : g_narrow
      assign wr_val = wdata_i[CNT_W-1:0];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = wr_val;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read of the pre-write value, writes
// committed on the next edge, ecall/mret trap bookkeeping and two counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 64,
  parameter logic [31:0]     MSTATUS_RST = 32'h0000_1800,
  parameter logic [XLEN-1:0] MVENDORID   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_valid_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            illegal_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam bit HAS_H = (CNT_W > XLEN);

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle, minstret;

  csr_op_e         op;
  logic [XLEN-1:0] mstatus_rd, old_val, new_val;
  logic            impl, access, wr_attempt, we;

  assign op = csr_op_e'(csr_op_i);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
    mstatus_rd[MSTATUS_MIE]  = mie_q;
  end

  always_comb begin
    impl    = 1'b1;
    old_val = '0;
    case (csr_addr_i)
      ADDR_MSTATUS:   old_val = mstatus_rd;
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MCAUSE:    old_val = mcause_q;
      ADDR_MCYCLE:    old_val = mcycle[XLEN-1:0];
      ADDR_MINSTRET:  old_val = minstret[XLEN-1:0];
      ADDR_MCYCLEH: begin
        old_val = XLEN'(mcycle >> XLEN);
        impl    = HAS_H;
      end
      ADDR_MINSTRETH: begin
        old_val = XLEN'(minstret >> XLEN);
        impl    = HAS_H;
      end
      ADDR_MVENDORID: old_val = MVENDORID;
      default:        impl    = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it never counts as a write.
  assign access     = csr_valid_i && (op != CSR_NOP);
  assign wr_attempt = (op == CSR_RW) || (csr_wdata_i != '0);
  assign illegal_o  = access && (!impl || ((csr_addr_i[11:10] == 2'b11) && wr_attempt));
  assign we         = access && !illegal_o && wr_attempt && !ecall_i && !mret_i;
  assign csr_rdata_o = (access && !illegal_o) ? old_val : '0;

  always_comb begin
    case (op)
      CSR_RS:  new_val = old_val | csr_wdata_i;
      CSR_RC:  new_val = old_val & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (ecall_i) begin
      mepc_d   = pc_i;
      mcause_d = XLEN'(CAUSE_ECALL_M);
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (we) begin
      case (csr_addr_i)
        ADDR_MSTATUS: begin
          mie_d  = new_val[MSTATUS_MIE];
          mpie_d = new_val[MSTATUS_MPIE];
        end
        ADDR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
        ADDR_MSCRATCH: mscratch_d = new_val;
        ADDR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= MSTATUS_RST[MSTATUS_MIE];
      mpie_q     <= MSTATUS_RST[MSTATUS_MPIE];
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (we && (csr_addr_i == ADDR_MCYCLE)),
    .wr_hi_i (we && (csr_addr_i == ADDR_MCYCLEH)),
    .wdata_i (new_val),
    .cnt_o   (mcycle)
  );

  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (retire_i),
    .wr_lo_i (we && (csr_addr_i == ADDR_MINSTRET)),
    .wr_hi_i (we && (csr_addr_i == ADDR_MINSTRETH)),
    .wdata_i (new_val),
    .cnt_o   (minstret)
  );

  assign redirect_o    = ecall_i || mret_i;
  assign redirect_pc_o = ecall_i ? {mtvec_q[XLEN-1:2], 2'b00} :
                         mret_i  ? mepc_q : '0;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file with hand-computed expected values.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        ecall, mret, retire;
  logic [31:0] pc;
  logic [31:0] csr_rdata;
  logic        illegal, redirect;
  logic [31:0] redirect_pc;

  int nvec = 0;
  int nmis = 0;

  localparam logic [1:0] NOP = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

  always #5 clk = ~clk;

  csr_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_valid_i   (csr_valid),
    .csr_op_i      (csr_op),
    .csr_addr_i    (csr_addr),
    .csr_wdata_i   (csr_wdata),
    .ecall_i       (ecall),
    .mret_i        (mret),
    .retire_i      (retire),
    .pc_i          (pc),
    .csr_rdata_o   (csr_rdata),
    .illegal_o     (illegal),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic ec, input logic mr,
                       input logic rt, input logic [31:0] p);
    csr_valid = v;  csr_op = op;  csr_addr = a;  csr_wdata = wd;
    ecall = ec;  mret = mr;  retire = rt;  pc = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, NOP, 12'h0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Reset state read via RS with zero operand
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    chk("rst_illegal", {31'b0, illegal}, 0);
    chk("rst_redirect", {31'b0, redirect}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("rs0_nowrite", csr_rdata, 32'h0000_1800);
    tick();

    // mtvec write with low bits dropped, then ecall
    drive(1, RW, 12'h305, 32'h8000_0103, 0, 0, 0, 0);
    chk("mtvec_old", csr_rdata, 0);
    tick();
    drive(0, NOP, 12'h0, 0, 1, 0, 0, 32'h8000_0010);
    chk("ecall_redirect", {31'b0, redirect}, 1);
    chk("ecall_pc", redirect_pc, 32'h8000_0100);
    chk("ecall_rdata_idle", csr_rdata, 0);
    tick();
    drive(1, RS, 12'h341, 0, 0, 0, 0, 0);
    chk("mepc_after_ecall", csr_rdata, 32'h8000_0010);
    tick();
    drive(1, RS, 12'h342, 0, 0, 0, 0, 0);
    chk("mcause", csr_rdata, 11);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("mstatus_ecall1", csr_rdata, 32'h0000_1800);
    tick();

    // MIE set, ecall, mret
    drive(1, RS, 12'h300, 8, 0, 0, 0, 0);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("mstatus_mie_set", csr_rdata, 32'h0000_1808);
    tick();
    drive(0, NOP, 12'h0, 0, 1, 0, 0, 32'h8000_0010);
    chk("ecall2_pc", redirect_pc, 32'h8000_0100);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("mstatus_after_ecall", csr_rdata, 32'h0000_1880);
    tick();
    drive(0, NOP, 12'h0, 0, 0, 1, 0, 0);
    chk("mret_redirect", {31'b0, redirect}, 1);
    chk("mret_pc", redirect_pc, 32'h8000_0010);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("mstatus_after_mret", csr_rdata, 32'h0000_1888);
    tick();

    // WARL and RC on mstatus
    drive(1, RC, 12'h300, 8, 0, 0, 0, 0);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("mstatus_rc", csr_rdata, 32'h0000_1880);
    tick();
    drive(1, RW, 12'h300, 32'h0, 0, 0, 0, 0);
    tick();
    drive(1, RW, 12'h300, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("mstatus_rw0", csr_rdata, 32'h0000_1800);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("mstatus_warl", csr_rdata, 32'h0000_1888);
    tick();

    // Illegal accesses
    drive(1, RW, 12'hF11, 5, 0, 0, 0, 0);
    chk("f11_rw_illegal", {31'b0, illegal}, 1);
    chk("f11_rw_rdata", csr_rdata, 0);
    tick();
    drive(1, RS, 12'hF11, 0, 0, 0, 0, 0);
    chk("f11_read_legal", {31'b0, illegal}, 0);
    chk("mvendorid", csr_rdata, 0);
    tick();
    drive(1, RS, 12'hF11, 1, 0, 0, 0, 0);
    chk("f11_rs_illegal", {31'b0, illegal}, 1);
    tick();
    drive(1, RW, 12'h7C0, 5, 0, 0, 0, 0);
    chk("7c0_illegal", {31'b0, illegal}, 1);
    tick();

    // mepc low bits forced clear
    drive(1, RW, 12'h341, 32'h8000_0203, 0, 0, 0, 0);
    tick();
    drive(1, RS, 12'h341, 0, 0, 0, 0, 0);
    chk("mepc_align", csr_rdata, 32'h8000_0200);
    tick();

    // mcycle wrap and write override
    drive(1, RW, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0, 0);
    tick();
    drive(1, RW, 12'hB80, 32'hFFFF_FFFF, 0, 0, 0, 0);
    tick();
    drive(0, NOP, 12'h0, 0, 0, 0, 0, 0);
    tick();
    drive(1, RS, 12'hB00, 0, 0, 0, 0, 0);
    chk("mcycle_wrap", csr_rdata, 0);
    tick();
    drive(1, RS, 12'hB80, 0, 0, 0, 0, 0);
    chk("mcycleh_wrap", csr_rdata, 0);
    tick();
    drive(1, RW, 12'hB00, 7, 0, 0, 0, 0);
    tick();
    drive(1, RS, 12'hB00, 0, 0, 0, 0, 0);
    chk("mcycle_wr7", csr_rdata, 7);
    tick();
    drive(1, RS, 12'hB00, 0, 0, 0, 0, 0);
    chk("mcycle_inc8", csr_rdata, 8);
    tick();

    // minstret: write overrides retire, then counts retires only
    drive(1, RW, 12'hB02, 0, 0, 0, 1, 0);
    tick();
    drive(0, NOP, 12'h0, 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    drive(1, RS, 12'hB02, 0, 0, 0, 0, 0);
    chk("minstret_3", csr_rdata, 3);
    tick();
    drive(1, RS, 12'hB02, 0, 0, 0, 0, 0);
    chk("minstret_hold", csr_rdata, 3);
    tick();

    // ecall beats a same-cycle CSR write
    drive(1, RW, 12'h340, 32'h1234, 0, 0, 0, 0);
    tick();
    drive(1, RW, 12'h340, 32'hABCD, 1, 0, 0, 32'h8000_0040);
    chk("prio_rdata", csr_rdata, 32'h1234);
    chk("prio_pc", redirect_pc, 32'h8000_0100);
    tick();
    drive(1, RS, 12'h340, 0, 0, 0, 0, 0);
    chk("mscratch_kept", csr_rdata, 32'h1234);
    tick();
    drive(1, RS, 12'h341, 0, 0, 0, 0, 0);
    chk("prio_mepc", csr_rdata, 32'h8000_0040);
    tick();
    drive(0, NOP, 12'h0, 0, 1, 1, 0, 32'h8000_0080);
    chk("ecall_over_mret_pc", redirect_pc, 32'h8000_0100);
    tick();

    // Reset overrides concurrent activity
    rst_n = 1'b0;
    drive(1, RW, 12'h340, 32'h99, 1, 0, 1, 32'h8000_0090);
    tick();
    rst_n = 1'b1;
    drive(1, RS, 12'h340, 0, 0, 0, 0, 0);
    chk("rst2_mscratch", csr_rdata, 0);
    tick();
    drive(1, RS, 12'h300, 0, 0, 0, 0, 0);
    chk("rst2_mstatus", csr_rdata, 32'h0000_1800);
    tick();
    drive(1, RS, 12'h305, 0, 0, 0, 0, 0);
    chk("rst2_mtvec", csr_rdata, 0);
    tick();
    drive(1, RS, 12'hB02, 0, 0, 0, 0, 0);
    chk("rst2_minstret", csr_rdata, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of all CSR data and PC ports.
REQ-002 SHALL have parameter CNT_W, default 64, width of mcycle/minstret counters (32 or 64).
REQ-003 SHALL have parameter MSTATUS_RST, default 32'h0000_1800, mstatus reset value (MPP=11).
REQ-004 SHALL have parameter MVENDORID, default 0, read-only value at 0xF11.
REQ-005 clk  input  1  clock; reset rst_n, synchronous, active-low.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 csr_valid  input  1  CSR instruction present this cycle.
REQ-008 csr_op  input  2  01 RW, 10 RS, 11 RC, 00 no-op (funct3[1:0]).
REQ-009 csr_addr  input  12  CSR address.
REQ-010 csr_wdata  input  XLEN  rs1 value or zero-extended zimm.
REQ-011 ecall  input  1  ecall retiring this cycle.
REQ-012 mret  input  1  mret retiring this cycle.
REQ-013 retire  input  1  one instruction retires this cycle.
REQ-014 pc  input  XLEN  PC of current instruction.
REQ-015 csr_rdata  output  XLEN  old CSR value, combinational.
REQ-016 illegal  output  1  illegal CSR access, combinational.
REQ-017 redirect  output  1  ecall or mret taking effect, combinational.
REQ-018 redirect_pc  output  XLEN  target PC when redirect=1, else 0.

Function
REQ-019 SHALL implement mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82 (h only when CNT_W=64), mvendorid 0xF11.
REQ-020 SHALL drive csr_rdata with the pre-write value in the same cycle as csr_valid; 0 when csr_valid=0 or illegal=1.
REQ-021 SHALL commit writes at the next rising clk edge: RW new=wdata, RS new=old|wdata, RC new=old&~wdata.
REQ-022 SHALL perform no write for RS/RC when csr_wdata==0 (read-only access legal).
REQ-023 SHALL assert illegal for unimplemented address, or any write attempt to addr[11:10]==2'b11; no state change.
REQ-024 SHALL treat mstatus as WARL: only MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; other bits read 0.
REQ-025 SHALL force mepc[1:0]=0 and mtvec[1:0]=0 on write (direct mode only).
REQ-026 On ecall: mepc<=pc, mcause<=11, MPIE<=MIE, MIE<=0; redirect=1, redirect_pc={mtvec[XLEN-1:2],2'b00} same cycle.
REQ-027 On mret: MIE<=MPIE, MPIE<=1; redirect=1, redirect_pc=mepc same cycle.
REQ-028 Priority: ecall > mret > CSR write; lower-priority actions suppressed that cycle.
REQ-029 mcycle SHALL increment by 1 every cycle out of reset; minstret by 1 when retire=1.
REQ-030 CSR write to a counter half SHALL override that counter's increment in that cycle; other half unchanged.
REQ-031 Counters SHALL wrap from all-ones to 0 without flag.
REQ-032 Back-to-back operations on consecutive cycles SHALL see prior-cycle writes (no hazard stall).

Reset
REQ-033 On rst_n=0 at clk edge: mstatus=MSTATUS_RST, all other CSRs and counters=0.
REQ-034 Reset SHALL override any concurrent ecall/mret/write/increment; outputs are combinational from reset state next cycle.

Structure
REQ-035 Shared package csr_pkg SHALL hold CSR address constants, cause code 11, csr_op encodings, mstatus bit positions.
REQ-036 SHALL instantiate sub-module csr_counter (CNT_W, inc, lo/hi write enables) twice, for mcycle and minstret.

Verification
REQ-037 Reset then read 0x300 via RS wdata=0 -> rdata=0x1800, illegal=0, no write.
REQ-038 RW 0x305 wdata=0x8000_0103, next cycle ecall pc=0x8000_0010 -> redirect_pc=0x8000_0100; then mepc=0x8000_0010, mcause=11, MIE=0.
REQ-039 Set MIE via RS 0x300 wdata=8, ecall, mret -> mret redirect_pc=0x8000_0010, MIE=1, MPIE=1.
REQ-040 RW 0xF11 wdata=5 -> illegal=1, rdata=0, mvendorid unchanged; RW 0x7C0 -> illegal=1.
REQ-041 RW mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF then 1 cycle -> mcycle/mcycleh=0; write mcycle=7 -> read next cycle=7, then 8.
REQ-042 ecall and RW 0x340 same cycle -> mscratch unchanged, ecall effects applied.
